// File: rtl/extremos_seq_pkg.sv
// Shared definitions for the extremos_seq max/min tracker: state encoding.
package extremos_seq_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ESPERA  = 3'd1,
    CMP_MAX = 3'd2,
    CMP_MIN = 3'd3,
    FIM     = 3'd4
  } estado_t;

endpackage

// File: rtl/extremos_seq_comparador.sv
// Unsigned N-bit magnitude comparator shared by the max and min passes.
module comparador_N #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         maior,
  output logic         menor,
  output logic         igual
);

  assign maior = (a > b);
  assign menor = (a < b);
  assign igual = (a == b);

endmodule

// File: rtl/extremos_seq.sv
// Sequential max/min tracker: one comparator time-shared between a max pass and
// a min pass for each sample after the first, with first-occurrence positions.
module extremos_seq
  import extremos_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic [CW-1:0] comprimento,
  input  logic [N-1:0]  dado,
  input  logic          dado_valido,
  output logic          pronto,
  output logic [N-1:0]  maximo,
  output logic [N-1:0]  minimo,
  output logic [CW-1:0] pos_max,
  output logic [CW-1:0] pos_min,
  output logic [CW-1:0] contagem,
  output logic          ocupado,
  output logic          fim
);

  localparam logic [CW-1:0] CW_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CW_UM   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  N_ZERO  = {N{1'b0}};

  estado_t       estado_r;
  estado_t       estado_prox_s;
  logic [CW-1:0] comprimento_r;
  logic [N-1:0]  amostra_r;
  logic [CW-1:0] indice_r;
  logic [N-1:0]  b_mux_s;
  logic          maior_s;
  logic          menor_s;
  logic          aceita_s;

  // pronto is itself the registered ESPERA decode, so it qualifies the transfer
  assign aceita_s = dado_valido & pronto;

  // ---------------- FSM ----------------

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r <= OCIOSO;
    end else begin
      estado_r <= estado_prox_s;
    end
  end

  // Next-state decode
  always_comb begin
    estado_prox_s = estado_r;
    case (estado_r)
      OCIOSO: begin
        if (iniciar) begin
          if (comprimento != CW_ZERO) begin
            estado_prox_s = ESPERA;
          end else begin
            estado_prox_s = FIM;
          end
        end else begin
          estado_prox_s = OCIOSO;
        end
      end
      ESPERA: begin
        if (aceita_s) begin
          if (contagem != CW_ZERO) begin
            estado_prox_s = CMP_MAX;
          end else if (comprimento_r == CW_UM) begin
            estado_prox_s = FIM;
          end else begin
            estado_prox_s = ESPERA;
          end
        end else begin
          estado_prox_s = ESPERA;
        end
      end
      CMP_MAX: estado_prox_s = CMP_MIN;
      CMP_MIN: begin
        if (contagem == comprimento_r) begin
          estado_prox_s = FIM;
        end else begin
          estado_prox_s = ESPERA;
        end
      end
      FIM:     estado_prox_s = OCIOSO;
      default: estado_prox_s = OCIOSO;
    endcase
  end

  // Status outputs registered from the next-state decode so they track the state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pronto  <= 1'b0;
      ocupado <= 1'b0;
      fim     <= 1'b0;
    end else begin
      pronto  <= (estado_prox_s == ESPERA);
      ocupado <= (estado_prox_s != OCIOSO);
      fim     <= (estado_prox_s == FIM);
    end
  end

  // ---------------- Datapath ----------------

  // B operand selects the current max during the max pass, the current min otherwise
  always_comb begin
    if (estado_r == CMP_MAX) begin
      b_mux_s = maximo;
    end else begin
      b_mux_s = minimo;
    end
  end

  comparador_N #(.N(N)) u_comparador (
    .a     (amostra_r),
    .b     (b_mux_s),
    .maior (maior_s),
    .menor (menor_s),
    .igual ()
  );

  // Result, counter and sample registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      comprimento_r <= CW_ZERO;
      amostra_r     <= N_ZERO;
      indice_r      <= CW_ZERO;
      contagem      <= CW_ZERO;
      maximo        <= N_ZERO;
      minimo        <= N_ZERO;
      pos_max       <= CW_ZERO;
      pos_min       <= CW_ZERO;
    end else begin
      case (estado_r)
        OCIOSO: begin
          if (iniciar) begin
            comprimento_r <= comprimento;
            contagem      <= CW_ZERO;
            if (comprimento == CW_ZERO) begin
              maximo  <= N_ZERO;
              minimo  <= N_ZERO;
              pos_max <= CW_ZERO;
              pos_min <= CW_ZERO;
            end
          end
        end
        ESPERA: begin
          if (aceita_s) begin
            contagem <= contagem + CW_UM;
            if (contagem == CW_ZERO) begin
              maximo  <= dado;
              minimo  <= dado;
              pos_max <= CW_ZERO;
              pos_min <= CW_ZERO;
            end else begin
              amostra_r <= dado;
              indice_r  <= contagem;
            end
          end
        end
        CMP_MAX: begin
          // strict compare keeps the first occurrence on ties
          if (maior_s) begin
            maximo  <= amostra_r;
            pos_max <= indice_r;
          end
        end
        CMP_MIN: begin
          if (menor_s) begin
            minimo  <= amostra_r;
            pos_min <= indice_r;
          end
        end
        FIM: begin
          contagem <= contagem;
        end
        default: begin
          contagem <= contagem;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_extremos_seq.sv
// Directed self-checking bench for extremos_seq with hand-computed expectations.
module tb_extremos_seq;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [3:0] comprimento;
  logic [3:0] dado;
  logic       dado_valido;
  logic       pronto;
  logic [3:0] maximo;
  logic [3:0] minimo;
  logic [3:0] pos_max;
  logic [3:0] pos_min;
  logic [3:0] contagem;
  logic       ocupado;
  logic       fim;

  int total = 0;
  int bad   = 0;

  extremos_seq #(.N(4), .CW(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .comprimento (comprimento),
    .dado        (dado),
    .dado_valido (dado_valido),
    .pronto      (pronto),
    .maximo      (maximo),
    .minimo      (minimo),
    .pos_max     (pos_max),
    .pos_min     (pos_min),
    .contagem    (contagem),
    .ocupado     (ocupado),
    .fim         (fim)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [3:0] len);
    iniciar     = 1'b1;
    comprimento = len;
    step();
    iniciar     = 1'b0;
  endtask

  // wait for pronto, toggling garbage on dado_valido meanwhile; then transfer one sample
  task automatic feed(input logic [3:0] val);
    int n;
    n = 0;
    while (!pronto && n < 20) begin
      dado_valido = ~dado_valido;
      dado        = 4'd8;
      step();
      n++;
    end
    if (n >= 20) chk("pronto_timeout", 32'(pronto), 32'd1);
    dado        = val;
    dado_valido = 1'b1;
    step();
    dado_valido = 1'b0;
  endtask

  task automatic wait_fim(input string tag);
    int n;
    n = 0;
    while (!fim && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_fim"}, 32'(fim), 32'd1);
    step();
    chk({tag, "_fim_pulse"}, 32'(fim), 32'd0);
    chk({tag, "_ocupado_off"}, 32'(ocupado), 32'd0);
  endtask

  task automatic check_res(input string tag, input logic [3:0] mx, input logic [3:0] pmx,
                           input logic [3:0] mn, input logic [3:0] pmn, input logic [3:0] cnt);
    chk({tag, "_max"}, 32'(maximo), 32'(mx));
    chk({tag, "_posmax"}, 32'(pos_max), 32'(pmx));
    chk({tag, "_min"}, 32'(minimo), 32'(mn));
    chk({tag, "_posmin"}, 32'(pos_min), 32'(pmn));
    chk({tag, "_cnt"}, 32'(contagem), 32'(cnt));
  endtask

  initial begin
    int pc;
    reset       = 1'b0;
    iniciar     = 1'b0;
    comprimento = 4'd0;
    dado        = 4'd0;
    dado_valido = 1'b0;
    step();
    step();
    check_res("reset", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("reset_pronto", 32'(pronto), 32'd0);
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    chk("reset_fim", 32'(fim), 32'd0);
    reset = 1'b1;
    step();

    // mid-run reset
    start(4'd5);
    chk("mid_ocupado", 32'(ocupado), 32'd1);
    chk("mid_pronto", 32'(pronto), 32'd1);
    feed(4'd3);
    feed(4'd9);
    chk("mid_max_before", 32'(maximo), 32'd3);
    #2 reset = 1'b0;
    #1;
    check_res("midrst", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("midrst_ocupado", 32'(ocupado), 32'd0);
    chk("midrst_pronto", 32'(pronto), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("midrst_idle", 32'(ocupado), 32'd0);

    // basic run, with an iniciar pulse mid-run that must be ignored
    start(4'd4);
    feed(4'd3);
    iniciar = 1'b1;
    comprimento = 4'd2;
    feed(4'd9);
    iniciar = 1'b0;
    feed(4'd1);
    feed(4'd7);
    wait_fim("basic");
    check_res("basic", 4'd9, 4'd1, 4'd1, 4'd2, 4'd4);

    // ties keep first occurrence
    start(4'd6);
    feed(4'd5); feed(4'd5); feed(4'd2); feed(4'd9); feed(4'd9); feed(4'd2);
    wait_fim("ties");
    check_res("ties", 4'd9, 4'd3, 4'd2, 4'd2, 4'd6);

    // extremes
    start(4'd3);
    feed(4'd15); feed(4'd0); feed(4'd15);
    wait_fim("ext");
    check_res("ext", 4'd15, 4'd0, 4'd0, 4'd1, 4'd3);

    // dado_valido held high: accepts at cycles 0,1,4,7,10,13,16 with dado = cycle number
    start(4'd7);
    dado_valido = 1'b1;
    pc = 0;
    for (int i = 0; i < 19; i++) begin
      dado = 4'(i);
      if (pronto) pc++;
      step();
    end
    dado_valido = 1'b0;
    chk("hold_pronto_cycles", 32'(pc), 32'd7);
    chk("hold_fim", 32'(fim), 32'd1);
    check_res("hold", 4'd13, 4'd5, 4'd0, 4'd0, 4'd7);
    step();
    chk("hold_fim_pulse", 32'(fim), 32'd0);

    // single-sample run: fim right after acceptance
    start(4'd1);
    feed(4'd6);
    chk("one_fim", 32'(fim), 32'd1);
    check_res("one", 4'd6, 4'd0, 4'd6, 4'd0, 4'd1);
    step();
    chk("one_fim_pulse", 32'(fim), 32'd0);
    step();
    step();
    chk("one_hold_max", 32'(maximo), 32'd6);

    // zero-length run clears results
    start(4'd0);
    chk("zero_fim", 32'(fim), 32'd1);
    chk("zero_ocupado", 32'(ocupado), 32'd1);
    check_res("zero", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    chk("zero_fim_pulse", 32'(fim), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/extremos_seq.md
# extremos_seq

Sequential max/min tracker that time-multiplexes a single `comparador_N` instance across a stream of N-bit samples. It accepts a run of `comprimento` samples over a valid/ready handshake. It reports the largest and smallest value, the index of the first occurrence of each, and a one-cycle completion pulse. It sits between a sample source (switch/memory sequencer) and the display/score logic.

## Interface
- `N`, default 4, sample width (≥2).
- `CW`, default 4, width of `comprimento`, `contagem`, `pos_max`, `pos_min`.
- `clock` in 1: rising-edge clock.
- `reset` in 1: reset, asynchronous, active-low.
- `iniciar` in 1: start pulse, sampled only in OCIOSO.
- `comprimento` in CW: samples in the run, latched on accepted `iniciar`.
- `dado` in N: sample value, unsigned.
- `dado_valido` in 1: source has a sample on `dado`.
- `pronto` out 1: block can accept a sample this cycle.
- `maximo` out N: largest sample so far.
- `minimo` out N: smallest sample so far.
- `pos_max` out CW: index (0-based) of the first occurrence of `maximo`.
- `pos_min` out CW: index of the first occurrence of `minimo`.
- `contagem` out CW: samples accepted in the current/last run.
- `ocupado` out 1: high in every state except OCIOSO.
- `fim` out 1: one-cycle pulse, run complete.

## Operation
- One clock; reset is asynchronous and active-low.
- States: OCIOSO, ESPERA, CMP_MAX, CMP_MIN, FIM.
- Reset (`reset`=0): state OCIOSO. All registers and outputs are 0: `maximo`, `minimo`, `pos_*`, `contagem`, `pronto`, `ocupado`, `fim`.
- OCIOSO:
  - `iniciar`=1 and `comprimento`≠0 → latch `comprimento`, clear `contagem`, go to ESPERA.
  - `iniciar`=1 and `comprimento`=0 → clear `contagem`, `maximo`, `minimo`, `pos_*`; go to FIM.
  - Results from the previous run hold until the next accepted `iniciar`.
- ESPERA:
  - `pronto`=1. A transfer occurs on a rising edge with `dado_valido`=1 and `pronto`=1.
  - First sample (`contagem`=0): load `maximo`=`minimo`=`dado`, `pos_max`=`pos_min`=0, and increment `contagem`. No comparison is made. Go to FIM if `comprimento`=1, else stay in ESPERA.
  - Later samples: register `dado` into the internal `amostra` register and go to CMP_MAX. The index is the pre-increment `contagem`; increment `contagem`.
- CMP_MAX:
  - Comparator A=`amostra`, B=`maximo`.
  - `maior`=1 → `maximo`←`amostra`, `pos_max`←index.
  - Go to CMP_MIN.
- CMP_MIN:
  - Comparator A=`amostra`, B=`minimo`.
  - `menor`=1 → `minimo`←`amostra`, `pos_min`←index.
  - Go to FIM if `contagem`=`comprimento`, else ESPERA.
- FIM: `fim`=1 for exactly one cycle, then go to OCIOSO.
- Ties:
  - Strict compare only; equal values never update, so positions report the first occurrence.
  - The comparator's `igual` output is unused.
- `iniciar` outside OCIOSO is ignored. `dado_valido` outside ESPERA is ignored; no sample is consumed.
- Mid-run reset: immediate return to OCIOSO with all outputs 0. A partial run is discarded.
- Arithmetic: unsigned. `contagem` never wraps, because a run ends at `comprimento` ≤ 2^CW−1.

## Timing
- `pronto` is a registered state decode: high only in ESPERA.
- Sample k≥1 is accepted on edge t:
  - max registers update at edge t+1;
  - min registers update at edge t+2;
  - `pronto` is high again in the cycle after edge t+2.
- Throughput:
  - first sample: 1 cycle;
  - each later sample: 3 cycles minimum, plus source stall.
- Completion:
  - After the final CMP_MIN at edge t+2, `fim` is high in cycle t+2..t+3.
  - For `comprimento`=1, `fim` follows the acceptance edge directly.
- `ocupado` goes high the cycle after the `iniciar` edge. It drops the cycle after `fim`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package: state encoding constants (OCIOSO=0, ESPERA=1, CMP_MAX=2, CMP_MIN=3, FIM=4; 3-bit state).
- Sub-module: one `comparador_N #(N)` instance.
  - A port tied to `amostra`.
  - B port muxed between `maximo` (CMP_MAX) and `minimo` (all other states).
  - Only `maior`/`menor` are qualified by state.
- Split the design into an FSM section and a datapath section (registers + B-mux) in the same module.

## Test plan
- Reset mid-run: start with `comprimento`=5, feed 2 samples, pulse `reset`=0 → all outputs 0 immediately, state OCIOSO. A new run works normally.
- Basic run: N=4, `comprimento`=4, samples 3,9,1,7 → `maximo`=9, `pos_max`=1, `minimo`=1, `pos_min`=2, `contagem`=4, one `fim` pulse.
- Ties: samples 5,5,2,9,9,2 → `maximo`=9, `pos_max`=3, `minimo`=2, `pos_min`=2 (first occurrences).
- Extremes: `comprimento`=3, samples 15,0,15 → `maximo`=15, `pos_max`=0, `minimo`=0, `pos_min`=1.
- Handshake:
  - hold `dado_valido`=1 continuously → `pronto` high exactly 1 of every 3 cycles after the first sample;
  - toggle `dado_valido` during CMP states → no extra samples counted.
- Boundaries:
  - `comprimento`=1, sample 6 → max=min=6, `fim` one cycle after acceptance;
  - `comprimento`=0 → `fim` with `contagem`=0 and zeroed results;
  - `iniciar` pulsed while `ocupado`=1 → ignored.
